// File: rtl/button_debounce.sv
// Push-button conditioning: 2-flop synchroniser, per-channel debounce,
// registered press/release pulses and sticky press flags.
//
// Ports:
//   clk            system clock, single domain
//   reset          asynchronous active-high reset, clears every flop
//   buttons_raw    raw pad inputs, active-high, asynchronous to clk
//   buttons_db     debounced levels
//   press_pulse    one cycle high on the first cycle of a 0->1 level
//   release_pulse  one cycle high on the first cycle of a 1->0 level
//   press_latched  sticky flag set by a press, cleared per bit
//   clear_latched  synchronous per-bit clear for press_latched
module button_debounce #(
    parameter int unsigned NUM_BUTTONS     = 3,
    parameter int unsigned DEBOUNCE_CYCLES = 10000,
    parameter int unsigned CNT_W           = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_BUTTONS-1:0] buttons_raw,
    output logic [NUM_BUTTONS-1:0] buttons_db,
    output logic [NUM_BUTTONS-1:0] press_pulse,
    output logic [NUM_BUTTONS-1:0] release_pulse,
    output logic [NUM_BUTTONS-1:0] press_latched,
    input  logic [NUM_BUTTONS-1:0] clear_latched
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NUM_BUTTONS-1:0] sync1_q;
    logic [NUM_BUTTONS-1:0] sync2_q;
    logic [NUM_BUTTONS-1:0] db_q;
    logic [NUM_BUTTONS-1:0] db_d;
    logic [NUM_BUTTONS-1:0] press_q;
    logic [NUM_BUTTONS-1:0] press_d;
    logic [NUM_BUTTONS-1:0] rel_q;
    logic [NUM_BUTTONS-1:0] rel_d;
    logic [NUM_BUTTONS-1:0] latch_q;
    logic [NUM_BUTTONS-1:0] latch_d;

    logic [NUM_BUTTONS-1:0][CNT_W-1:0] cnt_q;
    logic [NUM_BUTTONS-1:0][CNT_W-1:0] cnt_d;

    // Any cycle where the synchronised input agrees with the current
    // level restarts the count, so only an unbroken run of
    // DEBOUNCE_CYCLES disagreeing samples flips the level. The counter
    // is cleared on the flip, which keeps it below CNT_MAX + 1.
    always_comb begin
        db_d    = db_q;
        cnt_d   = cnt_q;
        press_d = '0;
        rel_d   = '0;
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            if (sync2_q[i] == db_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                db_d[i]    = sync2_q[i];
                cnt_d[i]   = '0;
                press_d[i] = sync2_q[i];
                rel_d[i]   = ~sync2_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
        // The set term is ORed in after the clear, so a press
        // arriving with a clear on the same bit keeps the flag set.
        latch_d = (latch_q & ~clear_latched) | press_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            db_q    <= '0;
            cnt_q   <= '0;
            press_q <= '0;
            rel_q   <= '0;
            latch_q <= '0;
        end else begin
            sync1_q <= buttons_raw;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
            rel_q   <= rel_d;
            latch_q <= latch_d;
        end
    end

    assign buttons_db    = db_q;
    assign press_pulse   = press_q;
    assign release_pulse = rel_q;
    assign press_latched = latch_q;

endmodule

// File: tb/tb_button_debounce.sv
// Self-checking bench for button_debounce with DEBOUNCE_CYCLES=4.
// Expected pulse events are queued when stimulus is driven.
module tb_button_debounce;

    localparam int NB = 3;
    localparam int DB = 4;
    localparam int LAT = DB + 2;

    logic          clk;
    logic          reset;
    logic [NB-1:0] buttons_raw;
    logic [NB-1:0] buttons_db;
    logic [NB-1:0] press_pulse;
    logic [NB-1:0] release_pulse;
    logic [NB-1:0] press_latched;
    logic [NB-1:0] clear_latched;

    typedef struct {
        int            cyc;
        logic [NB-1:0] prs;
        logic [NB-1:0] rel;
    } ev_t;

    ev_t sb[$];
    int  cyc;
    int  n_total;
    int  n_bad;

    button_debounce #(
        .NUM_BUTTONS    (NB),
        .DEBOUNCE_CYCLES(DB),
        .CNT_W          (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .buttons_raw  (buttons_raw),
        .buttons_db   (buttons_db),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .press_latched(press_latched),
        .clear_latched(clear_latched)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input int got,
                            input int exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h cyc=%0d",
                     tag, got, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_ev(input int at, input logic [NB-1:0] p,
                             input logic [NB-1:0] r);
        ev_t e;
        e.cyc = at;
        e.prs = p;
        e.rel = r;
        sb.push_back(e);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(2);
    endtask

    // Scoreboard: at every sample point either the head event is due
    // and its pulses are compared, or no pulse may be present.
    always @(negedge clk) begin
        if (sb.size() != 0 && sb[0].cyc <= cyc) begin
            ev_t e;
            e = sb.pop_front();
            check_eq("sb_cyc", cyc, e.cyc);
            check_eq("sb_press", int'(press_pulse), int'(e.prs));
            check_eq("sb_rel", int'(release_pulse), int'(e.rel));
        end else begin
            check_eq("sb_idle", int'({press_pulse, release_pulse}), 0);
        end
    end

    initial begin
        int n;
        n_total       = 0;
        n_bad         = 0;
        reset         = 1'b0;
        buttons_raw   = '0;
        clear_latched = '0;
        #1 reset = 1'b1;
        #1;
        check_eq("rst_db", int'(buttons_db), 0);
        check_eq("rst_lat", int'(press_latched), 0);
        tick(2);

        // 1: release with all pressed, then async reset mid-cycle
        reset       = 1'b0;
        buttons_raw = 3'b111;
        n           = cyc;
        expect_ev(n + LAT, 3'b111, 3'b000);
        tick(LAT - 1);
        check_eq("s1_db_early", int'(buttons_db), 0);
        tick(1);
        check_eq("s1_db", int'(buttons_db), 3'b111);
        check_eq("s1_lat", int'(press_latched), 3'b111);
        tick(1);
        check_eq("s1_lat_hold", int'(press_latched), 3'b111);
        #2 reset = 1'b1;
        #1;
        check_eq("s1_async_db", int'(buttons_db), 0);
        check_eq("s1_async_lat", int'(press_latched), 0);
        check_eq("s1_async_pp", int'(press_pulse), 0);
        buttons_raw = '0;
        tick(2);
        reset = 1'b0;
        tick(3);

        // 2: 3-cycle glitch rejected, then stable high accepted
        buttons_raw[0] = 1'b1;
        tick(3);
        buttons_raw[0] = 1'b0;
        tick(10);
        check_eq("s2_glitch_db", int'(buttons_db), 0);
        buttons_raw[0] = 1'b1;
        n = cyc;
        expect_ev(n + LAT, 3'b001, 3'b000);
        tick(LAT);
        check_eq("s2_db", int'(buttons_db), 3'b001);
        tick(2);

        // 3: press bit1, then bouncy release
        buttons_raw[1] = 1'b1;
        n = cyc;
        expect_ev(n + LAT, 3'b010, 3'b000);
        tick(LAT + 2);
        check_eq("s3_db_hi", int'(buttons_db), 3'b011);
        n = cyc;
        buttons_raw[1] = 1'b1; tick(1);
        buttons_raw[1] = 1'b0; tick(1);
        buttons_raw[1] = 1'b1; tick(1);
        buttons_raw[1] = 1'b0;
        expect_ev(n + 3 + LAT, 3'b000, 3'b010);
        tick(LAT + 6);
        check_eq("s3_db_lo", int'(buttons_db), 3'b001);
        check_eq("s3_lat", int'(press_latched), 3'b011);

        // 4: clear coincident with press loses, next clear wins
        buttons_raw[2] = 1'b1;
        n = cyc;
        expect_ev(n + LAT, 3'b100, 3'b000);
        tick(LAT - 1);
        clear_latched = 3'b100;
        tick(1);
        check_eq("s4_set_wins", int'(press_latched), 3'b111);
        tick(1);
        check_eq("s4_cleared", int'(press_latched), 3'b011);
        clear_latched = '0;
        tick(3);
        clear_latched = 3'b100;
        tick(2);
        check_eq("s4_idle_clr", int'(press_latched), 3'b011);
        clear_latched = '0;
        check_eq("s4_db", int'(buttons_db), 3'b101);

        // 5: independent channels, staggered rises
        buttons_raw = '0;
        pulse_reset();
        n = cyc;
        buttons_raw[0] = 1'b1;
        expect_ev(n + LAT, 3'b001, 3'b000);
        tick(2);
        buttons_raw[2] = 1'b1;
        expect_ev(n + 2 + LAT, 3'b100, 3'b000);
        tick(LAT + 6);
        check_eq("s5_db", int'(buttons_db), 3'b101);
        check_eq("s5_lat", int'(press_latched), 3'b101);

        // 6: reset while a press is still counting
        buttons_raw = '0;
        pulse_reset();
        buttons_raw[0] = 1'b1;
        tick(3);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        n = cyc;
        expect_ev(n + LAT, 3'b001, 3'b000);
        tick(LAT - 1);
        check_eq("s6_db_early", int'(buttons_db), 0);
        tick(1);
        check_eq("s6_db", int'(buttons_db), 3'b001);
        tick(4);

        check_eq("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
